vmcmp_seq: RTL and testbench
============================

VMCMP_SEQ -- requirements
Module: vmcmp_seq

Interface
REQ-001 Parameter: DATA_WIDTH, 64, VRF word width; fixed at 64.
REQ-002 Parameter: ADDR_WIDTH, 32, VRF word-address width.
REQ-003 Parameter: VL_WIDTH, 10, element-count width; max vl 512.
REQ-004 Port: clk  in  1  clock; all state on rising edge.
REQ-005 Port: rst  in  1  reset; synchronous and active-high.
REQ-006 Ports: req_valid in 1 / req_ready out 1: instruction handshake; transfer when both high.
REQ-007 Ports: req_opsel in 3, req_sew in 3, req_vl in VL_WIDTH, req_vs2_addr / req_vs1_addr / req_vd_addr in ADDR_WIDTH: compare op, element width 8<<sew bits, element count, source and destination base words.
REQ-008 Ports: rd_en out 1, rd_addr0 / rd_addr1 out ADDR_WIDTH, rd_data0 / rd_data1 in 64: VRF read; data valid exactly one cycle after rd_en.
REQ-009 Ports: cmp_valid out 1, cmp_vec0 / cmp_vec1 out 64, cmp_sew out 3, cmp_opsel out 3, cmp_start_idx out 3, cmp_addr out ADDR_WIDTH: compare-unit issue.
REQ-010 Ports: cmp_out_valid in 1, cmp_out_vec in 64: in-order compare results, fixed 6-cycle latency.
REQ-011 Ports: wr_en out 1, wr_addr out ADDR_WIDTH, wr_data out 64, wr_be out 8: mask writeback; always accepted.
REQ-012 Ports: busy out 1 (state != IDLE), done out 1 (one-cycle completion pulse).

Function
REQ-013 States IDLE, ISSUE, DRAIN; req_ready SHALL be high only in IDLE.
REQ-014 Chunk size E = 8>>sew elements; chunk count N = ceil(vl/E).
REQ-015 IDLE + handshake -> ISSUE, latching all req fields; chunk, result and word counters cleared.
REQ-016 In ISSUE, one rd_en per cycle; chunk k reads vs2_addr+k (rd_addr0) and vs1_addr+k (rd_addr1); ISSUE -> DRAIN after chunk N-1 is read.
REQ-017 cmp_valid SHALL be rd_en delayed one cycle; cmp_vec0 = rd_data0, cmp_vec1 = rd_data1, cmp_start_idx = 0, cmp_addr = vd_addr.
REQ-018 Each result contributes its low E bits to a 64-bit accumulator at bit offset (r*E) mod 64, r = result index.
REQ-019 Write SHALL fire in the result cycle that fills bit 63 or delivers result N-1: wr_addr = vd_addr + word index, wr_data = accumulator including that result, wr_be = 8'hFF; accumulator cleared the same cycle.
REQ-020 Result bits at element index >= vl SHALL be replaced per REQ-027.
REQ-021 DRAIN -> IDLE in the cycle of the final write; done pulses that cycle.
REQ-022 vl = 0 or sew > 3: no reads, no writes; ISSUE -> IDLE next cycle with done pulse.
REQ-023 cmp_out_valid while IDLE SHALL be ignored.
REQ-024 Throughput: N chunks complete N+7 cycles after acceptance; next request accepted the cycle after done.

Reset
REQ-025 On rst: state IDLE; req_ready 1; rd_en, cmp_valid, wr_en, busy, done 0; all address/data outputs and accumulator 0.
REQ-026 Reset mid-operation SHALL abort with no further write; in-flight results arriving afterwards are ignored per REQ-023.

Configuration
REQ-027 Macro VMCMP_SEQ_TAIL_ONES_EN: defined -> tail bits (element index >= vl) in the final word written 1; undefined -> written 0.

Structure
REQ-028 Shared package vmcmp_pkg: state enum, opsel encodings (EQ 0, NE 1, LTU 2, LT 3, LEU 4, LE 5, GTU 6, GT 7), SEW encodings, MASK_WORD_BITS = 64.
REQ-029 One sub-module natural: vmcmp_mask_acc (offset shift, accumulate, tail fill, write trigger).

Verification
REQ-030 sew=3, vl=4, opsel EQ, vs2 words equal vs1 words except chunk 2 -> one write, wr_data = 64'h000000000000000B, done 11 cycles after accept.
REQ-031 sew=0, vl=128, all compares true -> two writes, vd and vd+1, each 64'hFFFF...FFFF.
REQ-032 sew=2, vl=3, all true -> wr_data = 64'h7 (macro off) / all ones (macro on).
REQ-033 vl=0 -> no rd_en, no wr_en, done one cycle after accept.
REQ-034 rst asserted 3 cycles after accept of vl=64, sew=0 -> no wr_en thereafter, req_ready 1 next cycle.
REQ-035 Back-to-back requests with req_valid held high -> second accepted the cycle after first done; writes not interleaved.

Source files
------------

// File: rtl/vmcmp_pkg.sv
// Shared types and helpers for the vector mask-compare sequencer.
package vmcmp_pkg;

  localparam int unsigned MASK_WORD_BITS = 64;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  typedef enum logic [2:0] {
    OpEq  = 3'd0,
    OpNe  = 3'd1,
    OpLtu = 3'd2,
    OpLt  = 3'd3,
    OpLeu = 3'd4,
    OpLe  = 3'd5,
    OpGtu = 3'd6,
    OpGt  = 3'd7
  } opsel_e;

  typedef enum logic [2:0] {Sew8 = 3'd0, Sew16 = 3'd1, Sew32 = 3'd2, Sew64 = 3'd3} sew_e;

  // Number of 64-bit chunks needed to cover vl elements of width 8<<sew.
  function automatic logic [15:0] chunk_count(input logic [15:0] vl, input logic [1:0] sew);
    logic [15:0] elems;
    elems = 16'd8 >> sew;
    return (vl + elems - 16'd1) >> (2'd3 - sew);
  endfunction

endpackage

// File: rtl/vmcmp_mask_acc.sv
// Packs per-chunk compare results into 64-bit mask words and writes them back.
// Tail fill of the final word is selected by VMCMP_SEQ_TAIL_ONES_EN.
module vmcmp_mask_acc
  import vmcmp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned VL_WIDTH   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      res_valid,
  input  logic [7:0]                res_bits,
  input  logic [1:0]                sew,
  input  logic [VL_WIDTH-1:0]       vl,
  input  logic [15:0]               n_chunks,
  input  logic [ADDR_WIDTH-1:0]     vd_addr,
  output logic                      final_fire,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [MASK_WORD_BITS-1:0] wr_data,
  output logic [7:0]                wr_be
);

`ifdef VMCMP_SEQ_TAIL_ONES_EN
  localparam logic TailBit = 1'b1;
`else
  localparam logic TailBit = 1'b0;
`endif

  logic [15:0]               res_cnt_q;
  logic [ADDR_WIDTH-1:0]     word_cnt_q;
  logic [MASK_WORD_BITS-1:0] acc_q;
  logic                      wr_en_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_q;
  logic [MASK_WORD_BITS-1:0] wr_data_q;
  logic [7:0]                wr_be_q;

  logic [1:0]                e_log;
  logic [3:0]                elems;
  logic [15:0]               base;
  logic [5:0]                offset;
  logic [6:0]                top;
  logic                      last;
  logic                      fire;
  logic [16:0]               idx;
  logic [7:0]                chunk_bits;
  logic [MASK_WORD_BITS-1:0] hi_mask;
  logic [MASK_WORD_BITS-1:0] merged;

  always_comb begin
    e_log      = 2'd3 - sew;
    elems      = 4'd1 << e_log;
    base       = res_cnt_q << e_log;
    offset     = base[5:0];
    top        = {1'b0, offset} + {3'b000, elems};
    last       = (res_cnt_q == n_chunks - 16'd1);
    idx        = '0;
    chunk_bits = '0;
    for (int j = 0; j < 8; j++) begin
      idx = {1'b0, base} + 17'(j);
      if (4'(j) < elems) begin
        chunk_bits[j] = (idx >= 17'(vl)) ? TailBit : res_bits[j];
      end
    end
    // Everything above the last delivered chunk is tail in the final word.
    hi_mask = top[6] ? '0 : ({MASK_WORD_BITS{1'b1}} << top[5:0]);
    merged  = acc_q | (64'(chunk_bits) << offset);
    if (last && TailBit) merged = merged | hi_mask;
    final_fire = res_valid && last;
    fire       = res_valid && (top[6] || last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt_q  <= '0;
      word_cnt_q <= '0;
      acc_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      wr_en_q <= fire;
      wr_be_q <= fire ? 8'hFF : 8'h00;
      if (clear) begin
        res_cnt_q  <= '0;
        word_cnt_q <= '0;
        acc_q      <= '0;
      end else if (res_valid) begin
        res_cnt_q <= res_cnt_q + 16'd1;
        if (fire) begin
          wr_addr_q  <= vd_addr + word_cnt_q;
          wr_data_q  <= merged;
          acc_q      <= '0;
          word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
        end else begin
          acc_q <= merged;
        end
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;

endmodule

// File: rtl/vmcmp_seq.sv
// Vector mask-compare sequencer: reads operand words, issues them to the compare
// unit and packs results into mask words. Tail fill option: VMCMP_SEQ_TAIL_ONES_EN.
module vmcmp_seq
  import vmcmp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned VL_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_opsel,
  input  logic [2:0]            req_sew,
  input  logic [VL_WIDTH-1:0]   req_vl,
  input  logic [ADDR_WIDTH-1:0] req_vs2_addr,
  input  logic [ADDR_WIDTH-1:0] req_vs1_addr,
  input  logic [ADDR_WIDTH-1:0] req_vd_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr0,
  output logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [DATA_WIDTH-1:0] rd_data0,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  cmp_valid,
  output logic [DATA_WIDTH-1:0] cmp_vec0,
  output logic [DATA_WIDTH-1:0] cmp_vec1,
  output logic [2:0]            cmp_sew,
  output logic [2:0]            cmp_opsel,
  output logic [2:0]            cmp_start_idx,
  output logic [ADDR_WIDTH-1:0] cmp_addr,
  input  logic                  cmp_out_valid,
  input  logic [DATA_WIDTH-1:0] cmp_out_vec,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [7:0]            wr_be,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q;
  logic [2:0]            opsel_q;
  logic [2:0]            sew_q;
  logic [VL_WIDTH-1:0]   vl_q;
  logic [ADDR_WIDTH-1:0] vd_q;
  logic [15:0]           n_chunks_q;
  logic [15:0]           chunk_q;
  logic                  empty_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr0_q;
  logic [ADDR_WIDTH-1:0] rd_addr1_q;
  logic                  cmp_valid_q;
  logic                  done_q;

  logic accept;
  logic req_empty;
  logic res_valid;
  logic final_fire;
  logic unused_vec_hi;

  assign accept    = req_valid && (state_q == StIdle);
  assign req_empty = (req_vl == '0) || (req_sew > 3'(Sew64));
  // Results are only meaningful while an operation with reads is in flight.
  assign res_valid = cmp_out_valid && (state_q != StIdle) && !empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      opsel_q     <= '0;
      sew_q       <= '0;
      vl_q        <= '0;
      vd_q        <= '0;
      n_chunks_q  <= '0;
      chunk_q     <= '0;
      empty_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr0_q  <= '0;
      rd_addr1_q  <= '0;
      cmp_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmp_valid_q <= rd_en_q;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q    <= StIssue;
            opsel_q    <= req_opsel;
            sew_q      <= req_sew;
            vl_q       <= req_vl;
            vd_q       <= req_vd_addr;
            n_chunks_q <= chunk_count(16'(req_vl), req_sew[1:0]);
            chunk_q    <= '0;
            empty_q    <= req_empty;
            rd_en_q    <= !req_empty;
            rd_addr0_q <= req_vs2_addr;
            rd_addr1_q <= req_vs1_addr;
          end
        end
        StIssue: begin
          if (empty_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (chunk_q == n_chunks_q - 16'd1) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            chunk_q    <= chunk_q + 16'd1;
            rd_addr0_q <= rd_addr0_q + ADDR_WIDTH'(1);
            rd_addr1_q <= rd_addr1_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          if (final_fire) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  vmcmp_mask_acc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .VL_WIDTH  (VL_WIDTH)
  ) u_mask_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .res_valid (res_valid),
    .res_bits  (cmp_out_vec[7:0]),
    .sew       (sew_q[1:0]),
    .vl        (vl_q),
    .n_chunks  (n_chunks_q),
    .vd_addr   (vd_q),
    .final_fire(final_fire),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

  // Only the low E <= 8 result bits carry information.
  assign unused_vec_hi = ^cmp_out_vec[DATA_WIDTH-1:8];

  assign req_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign rd_en         = rd_en_q;
  assign rd_addr0      = rd_addr0_q;
  assign rd_addr1      = rd_addr1_q;
  assign cmp_valid     = cmp_valid_q;
  assign cmp_vec0      = cmp_valid_q ? rd_data0 : '0;
  assign cmp_vec1      = cmp_valid_q ? rd_data1 : '0;
  assign cmp_sew       = sew_q;
  assign cmp_opsel     = opsel_q;
  assign cmp_start_idx = 3'd0;
  assign cmp_addr      = vd_q;

endmodule

// File: tb/tb_vmcmp_seq.sv
// Directed bench for vmcmp_seq with a VRF model and a 6-cycle compare-unit model.
module tb_vmcmp_seq;

`ifdef VMCMP_SEQ_TAIL_ONES_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opsel;
  logic [2:0]  req_sew;
  logic [9:0]  req_vl;
  logic [31:0] req_vs2_addr, req_vs1_addr, req_vd_addr;
  logic        rd_en;
  logic [31:0] rd_addr0, rd_addr1;
  logic [63:0] rd_data0, rd_data1;
  logic        cmp_valid;
  logic [63:0] cmp_vec0, cmp_vec1;
  logic [2:0]  cmp_sew, cmp_opsel, cmp_start_idx;
  logic [31:0] cmp_addr;
  logic        cmp_out_valid;
  logic [63:0] cmp_out_vec;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        busy, done;

  vmcmp_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opsel(req_opsel), .req_sew(req_sew),
    .req_vl(req_vl), .req_vs2_addr(req_vs2_addr), .req_vs1_addr(req_vs1_addr),
    .req_vd_addr(req_vd_addr),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .cmp_valid(cmp_valid), .cmp_vec0(cmp_vec0), .cmp_vec1(cmp_vec1), .cmp_sew(cmp_sew),
    .cmp_opsel(cmp_opsel), .cmp_start_idx(cmp_start_idx), .cmp_addr(cmp_addr),
    .cmp_out_valid(cmp_out_valid), .cmp_out_vec(cmp_out_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRF: read data valid one cycle after rd_en.
  logic [63:0] vrf0 [16];
  logic [63:0] vrf1 [16];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data0 <= vrf0[rd_addr0[3:0]];
      rd_data1 <= vrf1[rd_addr1[3:0]];
    end
  end

  function automatic logic [63:0] cmp_model(logic [63:0] a, logic [63:0] b, logic [2:0] sew,
                                            logic [2:0] op);
    logic [63:0] r, m, ea, eb;
    logic        lt_u, lt_s, eq, bitv;
    int          w, ne;
    r = '0;
    if (sew > 3'd3) return r;
    w  = 8 << sew;
    ne = 8 >> sew;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < ne; i++) begin
      ea   = (a >> (i * w)) & m;
      eb   = (b >> (i * w)) & m;
      eq   = (ea == eb);
      lt_u = (ea < eb);
      lt_s = ($signed(ea << (64 - w)) < $signed(eb << (64 - w)));
      case (op)
        3'd0: bitv = eq;
        3'd1: bitv = !eq;
        3'd2: bitv = lt_u;
        3'd3: bitv = lt_s;
        3'd4: bitv = lt_u || eq;
        3'd5: bitv = lt_s || eq;
        3'd6: bitv = !(lt_u || eq);
        default: bitv = !(lt_s || eq);
      endcase
      r[i] = bitv;
    end
    return r;
  endfunction

  // Compare unit: fixed 6-cycle latency, in order.
  logic        pv [6];
  logic [63:0] pd [6];
  always @(posedge clk) begin
    pv[0] <= cmp_valid;
    pd[0] <= cmp_model(cmp_vec0, cmp_vec1, cmp_sew, cmp_opsel);
    for (int i = 1; i < 6; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign cmp_out_valid = pv[5];
  assign cmp_out_vec   = pd[5];

  logic unused_tb;
  assign unused_tb = ^{rd_addr0[31:4], rd_addr1[31:4], cmp_start_idx, cmp_addr};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] tailfill(logic [63:0] w, int n);
    logic [63:0] m;
    m = '1;
    m = m << n;
    return TAIL ? (w | m) : w;
  endfunction

  logic [31:0] wa [$];
  logic [63:0] wd [$];
  logic [7:0]  wbe[$];
  int          n_rd;
  int          lat;

  function automatic logic [63:0] qa(int i);
    return (i < wa.size()) ? 64'(wa[i]) : 64'hDEAD_BEEF;
  endfunction
  function automatic logic [63:0] qd(int i);
    return (i < wd.size()) ? wd[i] : 64'hDEAD_BEEF;
  endfunction

  task automatic vrf_distinct();
    for (int i = 0; i < 16; i++) begin
      vrf0[i] = {32'hC0DE_0000 | 32'(i), 32'h5555_0000 + 32'(i)};
      vrf1[i] = ~vrf0[i];
    end
  endtask

  task automatic vrf_equal();
    for (int i = 0; i < 16; i++) begin
      vrf0[i] = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101_0101_0101);
      vrf1[i] = vrf0[i];
    end
  endtask

  task automatic set_req(input logic [2:0] op, input logic [2:0] sew, input logic [9:0] vl,
                         input logic [31:0] vs2, input logic [31:0] vs1, input logic [31:0] vd);
    req_opsel = op; req_sew = sew; req_vl = vl;
    req_vs2_addr = vs2; req_vs1_addr = vs1; req_vd_addr = vd;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] op, input logic [2:0] sew, input logic [9:0] vl,
                        input logic [31:0] vs2, input logic [31:0] vs1, input logic [31:0] vd);
    int t_acc;
    wa.delete(); wd.delete(); wbe.delete();
    n_rd = 0;
    lat  = -1;
    set_req(op, sew, vl, vs2, vs1, vd);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t_acc = cyc;
    for (int i = 0; i < 200; i++) begin
      if (rd_en) n_rd++;
      if (wr_en) begin
        wa.push_back(wr_addr); wd.push_back(wr_data); wbe.push_back(wr_be);
      end
      if (done) begin
        lat = cyc - t_acc;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  int n_wr_idle, n_done_idle, n_res_idle;
  int acc_edges[$];
  int done_at[$];

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    set_req(3'd0, 3'd0, 10'd0, 32'd0, 32'd0, 32'd0);
    vrf_distinct();
    repeat (8) @(negedge clk);
    chk_eq("rst_req_ready", 64'(req_ready), 64'd1);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    chk_eq("rst_rd_en", 64'(rd_en), 64'd0);
    chk_eq("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    chk_eq("rst_wr_en", 64'(wr_en), 64'd0);
    chk_eq("rst_wr_data", wr_data, 64'd0);
    chk_eq("rst_wr_be", 64'(wr_be), 64'd0);
    chk_eq("rst_rd_addr0", 64'(rd_addr0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // sew=64, vl=4, chunk 2 unequal.
    vrf_distinct();
    for (int i = 0; i < 4; i++) begin
      vrf0[i]   = 64'h1000_0000_0000_0000 + 64'(i);
      vrf1[4+i] = vrf0[i];
    end
    vrf1[6] = vrf0[2] ^ 64'h1;
    run_op(3'd0, 3'd3, 10'd4, 32'd0, 32'd4, 32'd10);
    chk_eq("eq64_nrd", 64'(n_rd), 64'd4);
    chk_eq("eq64_nwr", 64'(wa.size()), 64'd1);
    chk_eq("eq64_addr", qa(0), 64'd10);
    chk_eq("eq64_data", qd(0), tailfill(64'hB, 4));
    chk_eq("eq64_be", (wbe.size() > 0) ? 64'(wbe[0]) : 64'h0, 64'hFF);
    chk_eq("eq64_lat", 64'(lat), 64'd11);

    // sew=8, vl=128, all true: two full words.
    vrf_equal();
    run_op(3'd0, 3'd0, 10'd128, 32'd0, 32'd0, 32'd20);
    chk_eq("full_nwr", 64'(wa.size()), 64'd2);
    chk_eq("full_addr0", qa(0), 64'd20);
    chk_eq("full_data0", qd(0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk_eq("full_addr1", qa(1), 64'd21);
    chk_eq("full_data1", qd(1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk_eq("full_lat", 64'(lat), 64'd23);

    // sew=32, vl=3: tail element in the last chunk.
    run_op(3'd0, 3'd2, 10'd3, 32'd0, 32'd0, 32'd5);
    chk_eq("tail_nwr", 64'(wa.size()), 64'd1);
    chk_eq("tail_data", qd(0), TAIL ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7);
    chk_eq("tail_lat", 64'(lat), 64'd9);

    // sew=16, vl=10, element 6 false.
    vrf1[1] = vrf1[1] ^ 64'h0000_0001_0000_0000;
    run_op(3'd0, 3'd1, 10'd10, 32'd0, 32'd0, 32'd3);
    chk_eq("sew16_data", qd(0), tailfill(64'h3BF, 10));
    chk_eq("sew16_addr", qa(0), 64'd3);
    chk_eq("sew16_lat", 64'(lat), 64'd10);

    // Unsigned and signed less-than on bytes.
    vrf_distinct();
    vrf0[2]  = 64'h0706_0504_0302_0100;
    vrf1[9]  = 64'h0404_0404_0404_0404;
    vrf0[3]  = 64'h0000_0000_0000_0080;
    vrf1[10] = 64'h0101_0101_0101_0101;
    run_op(3'd2, 3'd0, 10'd8, 32'd2, 32'd9, 32'd12);
    chk_eq("ltu_data", qd(0), tailfill(64'h0F, 8));
    chk_eq("ltu_lat", 64'(lat), 64'd8);
    run_op(3'd3, 3'd0, 10'd8, 32'd3, 32'd10, 32'd12);
    chk_eq("lt_data", qd(0), tailfill(64'hFF, 8));

    // Empty operations.
    run_op(3'd0, 3'd0, 10'd0, 32'd0, 32'd0, 32'd7);
    chk_eq("vl0_nrd", 64'(n_rd), 64'd0);
    chk_eq("vl0_nwr", 64'(wa.size()), 64'd0);
    chk_eq("vl0_lat", 64'(lat), 64'd1);
    run_op(3'd0, 3'd4, 10'd5, 32'd0, 32'd0, 32'd7);
    chk_eq("sew4_nrd", 64'(n_rd), 64'd0);
    chk_eq("sew4_nwr", 64'(wa.size()), 64'd0);
    chk_eq("sew4_lat", 64'(lat), 64'd1);

    // Reset three cycles after accept of vl=64, sew=8.
    vrf_equal();
    set_req(3'd0, 3'd0, 10'd64, 32'd0, 32'd0, 32'd14);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_req_ready", 64'(req_ready), 64'd1);
    chk_eq("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    n_wr_idle = 0; n_done_idle = 0; n_res_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en) n_wr_idle++;
      if (done) n_done_idle++;
      if (cmp_out_valid) n_res_idle++;
    end
    chk_eq("abort_nwr", 64'(n_wr_idle), 64'd0);
    chk_eq("abort_ndone", 64'(n_done_idle), 64'd0);
    chk_eq("abort_results_arrived", 64'(n_res_idle > 0), 64'd1);

    // Back-to-back with req_valid held high.
    wa.delete(); wd.delete();
    set_req(3'd0, 3'd3, 10'd2, 32'd0, 32'd0, 32'd8);
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (acc_edges.size() == 1) set_req(3'd0, 3'd2, 10'd4, 32'd0, 32'd0, 32'd9);
      if (acc_edges.size() >= 2) req_valid = 1'b0;
      if (req_valid && req_ready) acc_edges.push_back(cyc + 1);
      if (wr_en) begin
        wa.push_back(wr_addr); wd.push_back(wr_data);
      end
      if (done) done_at.push_back(cyc);
      if (done_at.size() == 2) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk_eq("b2b_ndone", 64'(done_at.size()), 64'd2);
    chk_eq("b2b_accept_gap",
           (acc_edges.size() > 1 && done_at.size() > 0) ? 64'(acc_edges[1] - done_at[0]) : 64'hX,
           64'd1);
    chk_eq("b2b_nwr", 64'(wa.size()), 64'd2);
    chk_eq("b2b_addr0", qa(0), 64'd8);
    chk_eq("b2b_data0", qd(0), tailfill(64'h3, 2));
    chk_eq("b2b_addr1", qa(1), 64'd9);
    chk_eq("b2b_data1", qd(1), tailfill(64'hF, 4));

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
